// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, RV opcode constants and the
// instruction field layout used by fetch, control and immediate generation.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Declared MSB-first so a 32-bit word casts directly onto the R-type layout.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and memory (slave).
// Handshake: master raises imem_req with imem_addr and holds both stable until
// the slave answers with a one-cycle imem_ack; imem_rdata/imem_err are only
// meaningful in the cycle imem_ack=1, and the master drops imem_req next cycle.
interface instr_fetch_unit_if #(
  parameter int XLEN = 64
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata, imem_err
  );
endinterface

// File: rtl/instr_fetch_unit_decode.sv
// Pure slice of an instruction word into its base RV fields; shared with the
// control unit and immediate generator.
module instr_field_decode
  import core_pkg::*;
(
  input  logic [31:0]   ir,
  output instr_fields_t fields
);
  assign fields = instr_fields_t'(ir);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches one 32-bit word per fetch_req over the
// imem req/ack bus and exposes the decoded fields of IR.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic                pc_write,
  input  logic [XLEN-1:0]     pc_next,
  instr_fetch_unit_if.master  imem,
  output logic [XLEN-1:0]     pc,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic [4:0]          rd,
  output logic [2:0]          funct3,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [6:0]          funct7,
  output logic                instr_valid,
  output logic                busy,
  output logic                fault,
  output fetch_state_t        state_dbg
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  fetch_state_t  state;
  logic [CW-1:0] tmo_cnt;
  instr_fields_t fields;

  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      busy           <= 1'b0;
      fault          <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      // The fetch address is latched separately, so PC may move during WAIT.
      if (pc_write && state != FAULT) pc <= pc_next;

      case (state)
        IDLE: begin
          if (fetch_req) begin
            instr_valid <= 1'b0;
            if (pc[1:0] == 2'b00) begin
              imem.imem_req  <= 1'b1;
              imem.imem_addr <= pc;
              busy           <= 1'b1;
              tmo_cnt        <= '0;
              state          <= WAIT;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            imem.imem_req <= 1'b0;
            busy          <= 1'b0;
            if (imem.imem_err) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              instr       <= imem.imem_rdata;
              instr_valid <= 1'b1;
              state       <= IDLE;
            end
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            imem.imem_req <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b1;
            state         <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        FAULT: begin
          imem.imem_req <= 1'b0;
          busy          <= 1'b0;
          instr_valid   <= 1'b0;
          fault         <= 1'b1;
        end
        default: begin
          imem.imem_req <= 1'b0;
          busy          <= 1'b0;
          fault         <= 1'b1;
          state         <= FAULT;
        end
      endcase
    end
  end

  instr_field_decode u_decode (
    .ir     (instr),
    .fields (fields)
  );

  assign opcode = fields.opcode;
  assign rd     = fields.rd;
  assign funct3 = fields.funct3;
  assign rs1    = fields.rs1;
  assign rs2    = fields.rs2;
  assign funct7 = fields.funct7;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized fetch stream checked against a PC/expected-word model.
module tb_instr_fetch_unit;
  import core_pkg::*;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            fetch_req;
  logic            pc_write;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic            instr_valid;
  logic            busy;
  logic            fault;
  fetch_state_t    state_dbg;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC('0), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc_write    (pc_write),
    .pc_next     (pc_next),
    .imem        (bus.master),
    .pc          (pc),
    .instr       (instr),
    .opcode      (opcode),
    .rd          (rd),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct7      (funct7),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fault       (fault),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req      = 1'b0;
    pc_write       = 1'b0;
    pc_next        = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_err   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_pc(input logic [XLEN-1:0] v);
    pc_write = 1'b1;
    pc_next  = v;
    tick();
    pc_write = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (pc !== 64'h0 || instr !== 32'h0000_0013 || instr_valid !== 1'b0 ||
        bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0 || busy !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b addr=%h busy=%b fault=%b, required 0/00000013/0/0/0/0/0",
               pc, instr, instr_valid, bus.imem_req, bus.imem_addr, busy, fault);
    end
    set_pc(64'h40);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || bus.imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_wait: busy=%b req=%b, required 1/1", busy, bus.imem_req);
    end
    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pc !== 64'h0 || instr !== 32'h0000_0013 || bus.imem_req !== 1'b0 ||
        instr_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      n_bad++;
      $display("FAIL reset_async: pc=%h instr=%h req=%b valid=%b busy=%b state=%0d, required 0/00000013/0/0/0/IDLE",
               pc, instr, bus.imem_req, instr_valid, busy, state_dbg);
    end
    tick();
    reset = 1'b0;
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    tick();
    bus.imem_ack = 1'b0;
    n_cmp++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_late_ack: instr=%h valid=%b req=%b, required 00000013/0/0",
               instr, instr_valid, bus.imem_req);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_request: req=%b addr=%h busy=%b valid=%b, required 1/0/1/0",
               bus.imem_req, bus.imem_addr, busy, instr_valid);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0031_00B3;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== 32'h0031_00B3 || bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_complete: valid=%b instr=%h req=%b busy=%b, required 1/003100b3/0/0",
               instr_valid, instr, bus.imem_req, busy);
    end
    n_cmp++;
    if (opcode !== 7'd51 || rd !== 5'd1 || rs1 !== 5'd2 || rs2 !== 5'd3 ||
        funct3 !== 3'd0 || funct7 !== 7'd0) begin
      n_bad++;
      $display("FAIL zw_fields: op=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%0d, required 51/1/2/3/0/0",
               opcode, rd, rs1, rs2, funct3, funct7);
    end
    tick();
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL zw_valid_hold: valid=%b, required 1", instr_valid);
    end
  endtask

  task automatic test_wait_pc_write();
    logic [31:0] word;
    word = $urandom;
    do_reset();
    set_pc(64'h8);
    fetch_req = 1'b1;                 // c0
    tick();
    fetch_req = 1'b0;                 // c1
    tick();                           // c2
    pc_write = 1'b1;
    pc_next  = 64'hC;
    fetch_req = 1'b1;                 // ignored while waiting
    for (int c = 3; c <= 5; c++) begin
      tick();
      pc_write  = 1'b0;
      fetch_req = 1'b0;
      n_cmp++;
      if (bus.imem_addr !== 64'h8 || bus.imem_req !== 1'b1 || pc !== 64'hC) begin
        n_bad++;
        $display("FAIL wait_c%0d: addr=%h req=%b pc=%h, required 8/1/c", c, bus.imem_addr, bus.imem_req, pc);
      end
    end
    bus.imem_ack   = 1'b1;            // ack at c5
    bus.imem_rdata = word;
    tick();
    bus.imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== word || pc !== 64'hC) begin
      n_bad++;
      $display("FAIL wait_complete: valid=%b instr=%h pc=%h, required 1/%h/c", instr_valid, instr, pc, word);
    end
  endtask

  task automatic test_same_cycle();
    set_pc(64'h10);
    fetch_req = 1'b1;
    pc_write  = 1'b1;
    pc_next   = 64'h14;
    tick();
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    n_cmp++;
    if (bus.imem_addr !== 64'h10 || pc !== 64'h14 || bus.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle: addr=%h pc=%h req=%b valid=%b, required 10/14/1/0",
               bus.imem_addr, pc, bus.imem_req, instr_valid);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_006F;
    tick();
    bus.imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || opcode !== 7'd111) begin
      n_bad++;
      $display("FAIL same_cycle_done: valid=%b op=%0d, required 1/111", instr_valid, opcode);
    end
  endtask

  task automatic test_error();
    logic [31:0] good;
    good = $urandom;
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req      = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = good;
    tick();
    fetch_req      = 1'b1;
    bus.imem_ack   = 1'b0;
    tick();
    fetch_req      = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_err   = 1'b1;
    bus.imem_rdata = ~good;
    tick();
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    n_cmp++;
    if (fault !== 1'b1 || instr !== good || bus.imem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bus_error: fault=%b instr=%h req=%b busy=%b valid=%b, required 1/%h/0/0/0",
               fault, instr, bus.imem_req, busy, instr_valid, good);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      n_cmp++;
      if (bus.imem_req !== 1'b1 || fault !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_wait_%0d: req=%b fault=%b, required 1/0", i, bus.imem_req, fault);
      end
      tick();
    end
    n_cmp++;
    if (bus.imem_req !== 1'b0 || fault !== 1'b1 || state_dbg !== FAULT) begin
      n_bad++;
      $display("FAIL timeout_fault: req=%b fault=%b state=%0d, required 0/1/FAULT",
               bus.imem_req, fault, state_dbg);
    end
    fetch_req = 1'b1;
    pc_write  = 1'b1;
    pc_next   = 64'h40;
    repeat (3) tick();
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b0 || fault !== 1'b1 || pc !== 64'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_sticky: req=%b fault=%b pc=%h busy=%b, required 0/1/0/0",
               bus.imem_req, fault, pc, busy);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    set_pc(64'h6);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_cmp++;
    if (fault !== 1'b1 || bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned: fault=%b req=%b busy=%b, required 1/0/0", fault, bus.imem_req, busy);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.imem_req !== 1'b0 || fault !== 1'b1) begin
      n_bad++;
      $display("FAIL misaligned_hold: req=%b fault=%b, required 0/1", bus.imem_req, fault);
    end
  endtask

  // Random fetch stream: PC model tracks every write, the expected queue
  // holds each word memory returns, and the fetch address is the PC as it
  // stood when fetch_req was accepted.
  task automatic test_random();
    logic [XLEN-1:0] pc_model;
    logic [XLEN-1:0] new_pc;
    logic [XLEN-1:0] exp_addr;
    logic [31:0]     word;
    logic [31:0]     exp_word;
    int              waits;
    do_reset();
    new_pc = {$urandom, $urandom} & ~64'h3;
    set_pc(new_pc);
    pc_model = new_pc;
    for (int n = 0; n < 40; n++) begin
      fetch_req = 1'b1;
      exp_addr  = pc_model;
      if ($urandom_range(0, 1) == 1) begin
        new_pc   = {$urandom, $urandom} & ~64'h3;
        pc_write = 1'b1;
        pc_next  = new_pc;
        pc_model = new_pc;
      end
      tick();
      fetch_req = 1'b0;
      pc_write  = 1'b0;
      waits = $urandom_range(0, 6);
      word  = $urandom;
      exp_q.push_back(word);
      for (int w = 0; w < waits; w++) begin
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr || instr_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_wait_%0d_%0d: req=%b addr=%h valid=%b, required 1/%h/0",
                   n, w, bus.imem_req, bus.imem_addr, instr_valid, exp_addr);
        end
        if ($urandom_range(0, 3) == 0) begin
          new_pc   = {$urandom, $urandom} & ~64'h3;
          pc_write = 1'b1;
          pc_next  = new_pc;
          pc_model = new_pc;
        end
        tick();
        pc_write = 1'b0;
      end
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL rand_ack_%0d: req=%b addr=%h, required 1/%h", n, bus.imem_req, bus.imem_addr, exp_addr);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      tick();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      exp_word = exp_q.pop_front();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== exp_word || opcode !== exp_word[6:0] ||
          rs2 !== exp_word[24:20] || pc !== pc_model || fault !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_done_%0d: valid=%b instr=%h op=%h rs2=%h pc=%h fault=%b, required 1/%h/%h/%h/%h/0",
                 n, instr_valid, instr, opcode, rs2, pc, fault,
                 exp_word, exp_word[6:0], exp_word[24:20], pc_model);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_pc_write();
    test_same_cycle();
    test_error();
    test_timeout();
    test_misaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the multicycle RV64 core: owns PC and instruction register (IR), fetches 32-bit instruction words from instruction memory over a req/ack handshake. Sits directly upstream of the control unit: on its fetch request it reads memory at PC, latches the word into IR and drives the decoded fields, including the 7-bit opcode the control unit consumes. PC is updated from the datapath (ALU result) when the control unit asserts its PC write.

Parameters:
XLEN, 64, PC/address width
RESET_PC, 64'h0, PC value after reset
TIMEOUT, 16, max cycles in WAIT without imem_ack before fault (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
fetch_req  in  1  from control unit (load_ir): start a fetch at current PC
pc_write  in  1  from control unit: load pc_next into PC
pc_next  in  XLEN  new PC from ALU/datapath mux
imem_req  out  1  memory request, registered
imem_addr  out  XLEN  fetch address, registered, stable while imem_req=1
imem_ack  in  1  memory response valid, one-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
imem_err  in  1  bus error, qualified by imem_ack
pc  out  XLEN  current PC register
instr  out  32  IR contents
opcode  out  7  instr[6:0]
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
instr_valid  out  1  IR holds a completed fetch
busy  out  1  fetch in flight (state WAIT)
fault  out  1  sticky fetch fault

Behaviour:
- Reset (async): pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, imem_addr=0, busy=0, fault=0, timeout counter=0, state IDLE. Reset mid-fetch aborts; a late ack after reset is ignored.
- States: IDLE, WAIT, FAULT.
- IDLE: fetch_req=1 and pc[1:0]==0 -> next cycle imem_addr=pc (value before any same-cycle pc_write), imem_req=1, busy=1, instr_valid=0, counter=0, go WAIT. fetch_req=1 with pc[1:0]!=0 -> go FAULT, no request issued.
- WAIT: imem_req held 1, imem_addr stable. fetch_req ignored.
  - imem_ack=1, imem_err=0: next cycle instr=imem_rdata, instr_valid=1, imem_req=0, busy=0, go IDLE.
  - imem_ack=1, imem_err=1: IR unchanged, imem_req=0, go FAULT.
  - no ack: counter+1; counter reaching TIMEOUT-1 without ack -> imem_req=0, go FAULT.
- FAULT: fault=1, imem_req=0, busy=0, instr_valid=0; sticky until reset; fetch_req ignored.
- Latency: fetch_req at cycle 0 -> imem_req at 1; ack at cycle k>=1 -> instr_valid at k+1. Zero-wait memory: 2 cycles fetch_req-to-valid.
- instr_valid stays 1 until the next accepted fetch_req (cleared the following cycle).
- imem_ack outside WAIT ignored (no IR update).
- pc_write: PC<=pc_next next cycle, in any state except FAULT; allowed during WAIT (fetch address already latched). No alignment masking; misalignment detected at next fetch.
- Decoded fields are combinational slices of IR, never of imem_rdata.

Decomposition:
- Shared package core_pkg: fetch_state_t enum {IDLE, WAIT, FAULT}; RV opcode constants (OP_R=7'd51, OP_I=7'd19, OP_LOAD=7'd3, OP_STORE=7'd35, OP_BRANCH=7'd99, OP_JAL=7'd111); NOP_INSTR=32'h0000_0013; instr_fields_t packed struct.
- Sub-module: instr_field_decode (combinational, IR -> opcode/rd/funct3/rs1/rs2/funct7), reused by control unit and immediate generator.

Test Plan:
- Reset: pulse reset mid-WAIT -> pc=0, instr=32'h00000013, imem_req=0, instr_valid=0 same cycle; ack 2 cycles later ignored.
- Zero-wait fetch: pc=0, fetch_req at c0, ack with rdata=32'h003100B3 at c1 -> instr_valid at c2, opcode=51, rd=1, rs1=2, rs2=3, funct3=0, funct7=0.
- Wait states + pc_write: fetch at pc=8, pc_write pc_next=12 at c2, ack at c5 -> imem_addr stays 8 through c5, pc=12 from c3, instr from addr 8.
- Same-cycle fetch_req+pc_write in IDLE, pc=16, pc_next=20 -> imem_addr=16, pc=20.
- Error/timeout: ack with imem_err=1 -> fault=1, IR unchanged; separately no ack for 16 cycles -> imem_req drops, fault=1, later fetch_req ignored.
- Misaligned: pc_write pc_next=6, fetch_req -> imem_req never asserts, fault=1 next cycle.
